cache_rd_arbiter: RTL and testbench
===================================

CACHE_RD_ARBITER -- requirements
Module: cache_rd_arbiter

Interface
REQ-001 SHALL have parameter LINE_BEATS, default 4, giving the 32-bit beats per cache-line refill (power of two, 2..16).
REQ-002 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port inst_rd_req  in  1  icache read request, held until accepted.
REQ-005 SHALL have port inst_rd_uncached  in  1  icache request is a single-beat read.
REQ-006 SHALL have port inst_rd_addr  in  32  icache physical address.
REQ-007 SHALL have port inst_rd_rdy  out  1  icache request accepted this cycle.
REQ-008 SHALL have port inst_ret_valid  out  1  return beat for icache.
REQ-009 SHALL have port inst_ret_last  out  1  final icache return beat.
REQ-010 SHALL have ports data_rd_req, data_rd_uncached, data_rd_addr, data_rd_rdy, data_ret_valid, data_ret_last, mirroring REQ-004..REQ-009 for the dcache.
REQ-011 SHALL have port ret_data  out  32  shared return data, equal to rdata.
REQ-012 SHALL have port arid  out  4  AXI read ID: 0 = inst, 1 = data.
REQ-013 SHALL have port araddr  out  32  AXI read address.
REQ-014 SHALL have port arlen  out  8  AXI burst length minus one.
REQ-015 SHALL have port arsize  out  3  AXI beat size, constant 3'b010.
REQ-016 SHALL have ports arvalid out 1 and arready in 1, the AXI AR handshake.
REQ-017 SHALL have ports rid in 4, rdata in 32, rlast in 1, rvalid in 1, and rready out 1, the AXI R channel.

Function
REQ-018 SHALL implement the FSM IDLE -> AR -> R -> IDLE, with one outstanding read at most.
REQ-019 In IDLE, a request SHALL be granted with the same-cycle rd_rdy pulse to the winner, and address, uncached flag, and ID SHALL be latched; the FSM SHALL go to AR next cycle.
REQ-020 Arbitration: data wins over inst when both requests are high, except when starve_cnt == 3 with inst pending, in which case inst wins.
REQ-021 starve_cnt (2 bit) SHALL increment when data is granted while inst_rd_req is high, clear on any inst grant, and saturate at 3.
REQ-022 The losing requester's rd_rdy SHALL stay 0; at most one rd_rdy SHALL be high per cycle.
REQ-023 In AR: arvalid = 1 and arid, araddr, and arlen are stable until arready, then the FSM goes to R. arvalid SHALL never drop before arready.
REQ-024 Uncached request: araddr = addr, arlen = 0.
REQ-025 Cached request: araddr = addr with its low log2(LINE_BEATS*4) bits cleared, arlen = LINE_BEATS-1.
REQ-026 In R: rready = 1.
REQ-027 A beat with rvalid && rid == latched ID SHALL assert the granted side's ret_valid, and ret_last = rlast, in the same cycle (combinational).
REQ-028 A beat whose rid does not match SHALL be consumed and not forwarded.
REQ-029 A forwarded beat with rlast SHALL return the FSM to IDLE; no new grant SHALL occur in that same cycle (one-cycle bubble).
REQ-030 The non-granted side's ret_valid and ret_last SHALL be 0 at all times.
REQ-031 rd_rdy SHALL never assert outside IDLE.
REQ-032 arvalid SHALL be 0 outside AR, and rready SHALL be 0 outside R.

Reset
REQ-033 On reset (any time, including mid-burst), the FSM SHALL go to IDLE and starve_cnt to 0; in-flight transactions are abandoned.
REQ-034 During reset: arvalid, rready, all rd_rdy, all ret_valid and ret_last = 0; arid, araddr, arlen = 0.
REQ-035 After reset deasserts, the first grant SHALL be possible on the first clock edge.

Verification
REQ-036 Inst-only cached read of 0x1C00_0014, arready after 2 cycles, 4 beats -> inst_rd_rdy pulse, araddr=0x1C00_0010, arlen=3, arid=0, four inst_ret_valid, inst_ret_last on beat 4, FSM back in IDLE.
REQ-037 Simultaneous inst and data uncached read of 0x8000_0003 -> data_rd_rdy only, araddr=0x8000_0003, arlen=0, arid=1, one data_ret_valid with data_ret_last; inst granted on the second cycle after it.
REQ-038 inst_rd_req held high while data requests 4 back-to-back -> grants data, data, data, inst (starve_cnt reaches 3 then clears).
REQ-039 Stray beat rid=2 during an inst burst -> rready high, no ret_valid on either side, burst completes normally.
REQ-040 Reset asserted on beat 2 of a data burst -> arvalid, rready, and ret_valid go to 0 immediately; after release, a new inst request is granted with arid=0.

Source files
------------

// File: rtl/cache_rd_arbiter.sv
// Arbitrates icache and dcache line/word reads onto one AXI read port.
// One read is outstanding at a time; beats are steered back by AXI ID.
module cache_rd_arbiter #(
    parameter int LINE_BEATS = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_rd_req,
    input  logic        inst_rd_uncached,
    input  logic [31:0] inst_rd_addr,
    output logic        inst_rd_rdy,
    output logic        inst_ret_valid,
    output logic        inst_ret_last,

    input  logic        data_rd_req,
    input  logic        data_rd_uncached,
    input  logic [31:0] data_rd_addr,
    output logic        data_rd_rdy,
    output logic        data_ret_valid,
    output logic        data_ret_last,

    output logic [31:0] ret_data,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam int          NUM_REQ   = 2;
    localparam logic [31:0] LINE_MASK = ~((32'(LINE_BEATS) * 32'd4) - 32'd1);
    localparam logic [7:0]  BURST_LEN = 8'(LINE_BEATS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_R} state_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_req_t;

    state_t  state, state_nxt;
    ar_req_t ar_q, ar_nxt;
    logic [1:0] starve_cnt, starve_nxt;

    // Requester index doubles as the AXI ID: 0 = inst, 1 = data.
    logic [NUM_REQ-1:0]       req, uncached, grant, ret_vld;
    logic [NUM_REQ-1:0][31:0] addr;
    logic                     inst_win, beat_hit, win;

    assign req      = {data_rd_req, inst_rd_req};
    assign uncached = {data_rd_uncached, inst_rd_uncached};
    assign addr     = {data_rd_addr, inst_rd_addr};

    // Data has priority unless inst has lost three grants in a row.
    assign inst_win = req[0] && (!req[1] || starve_cnt == 2'd3);
    assign grant[0] = (state == ST_IDLE) && !reset && inst_win;
    assign grant[1] = (state == ST_IDLE) && !reset && req[1] && !inst_win;
    assign win      = grant[1];

    assign inst_rd_rdy = grant[0];
    assign data_rd_rdy = grant[1];

    always_comb begin
        ar_nxt     = ar_q;
        state_nxt  = state;
        starve_nxt = starve_cnt;
        case (state)
            ST_IDLE: begin
                if (|grant) begin
                    ar_nxt.id   = {3'd0, win};
                    ar_nxt.addr = uncached[win] ? addr[win] : (addr[win] & LINE_MASK);
                    ar_nxt.len  = uncached[win] ? 8'd0 : BURST_LEN;
                    state_nxt   = ST_AR;
                end
                if (grant[0])
                    starve_nxt = 2'd0;
                else if (grant[1] && req[0] && starve_cnt != 2'd3)
                    starve_nxt = starve_cnt + 2'd1;
            end
            ST_AR: begin
                if (arready)
                    state_nxt = ST_R;
            end
            ST_R: begin
                if (beat_hit && rlast)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            ar_q       <= '0;
            starve_cnt <= 2'd0;
        end else begin
            state      <= state_nxt;
            ar_q       <= ar_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    assign arvalid = (state == ST_AR);
    assign arid    = ar_q.id;
    assign araddr  = ar_q.addr;
    assign arlen   = ar_q.len;
    assign arsize  = 3'b010;
    assign rready  = (state == ST_R);

    // Beats with a foreign ID are accepted (rready) but never forwarded.
    assign beat_hit = (state == ST_R) && rvalid && (rid == ar_q.id);
    assign ret_data = rdata;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_ret
        assign ret_vld[g] = beat_hit && (ar_q.id == 4'(g));
    end

    assign inst_ret_valid = ret_vld[0];
    assign inst_ret_last  = ret_vld[0] && rlast;
    assign data_ret_valid = ret_vld[1];
    assign data_ret_last  = ret_vld[1] && rlast;

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Scoreboard bench for cache_rd_arbiter: directed transactions push expected
// grants, AR beats and return beats; a negedge monitor pops and compares.
module tb_cache_rd_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_rd_req, inst_rd_uncached, inst_rd_rdy, inst_ret_valid, inst_ret_last;
    logic [31:0] inst_rd_addr;
    logic        data_rd_req, data_rd_uncached, data_rd_rdy, data_ret_valid, data_ret_last;
    logic [31:0] data_rd_addr;
    logic [31:0] ret_data;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rlast, rvalid, rready;

    int n_cmp = 0;
    int n_err = 0;

    int          gnt_q[$];
    logic [43:0] ar_q[$];
    logic [35:0] ret_q[$];

    always #5 clk = ~clk;

    cache_rd_arbiter #(.LINE_BEATS(4)) dut (
        .clk(clk), .reset(reset),
        .inst_rd_req(inst_rd_req), .inst_rd_uncached(inst_rd_uncached),
        .inst_rd_addr(inst_rd_addr), .inst_rd_rdy(inst_rd_rdy),
        .inst_ret_valid(inst_ret_valid), .inst_ret_last(inst_ret_last),
        .data_rd_req(data_rd_req), .data_rd_uncached(data_rd_uncached),
        .data_rd_addr(data_rd_addr), .data_rd_rdy(data_rd_rdy),
        .data_ret_valid(data_ret_valid), .data_ret_last(data_ret_last),
        .ret_data(ret_data),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [35:0] mk_ret(input int side, input logic last, input logic [31:0] d);
        return {side == 0, (side == 0) && last, side == 1, (side == 1) && last, d};
    endfunction

    function automatic logic [31:0] beat_data(input int tag, input int b);
        return 32'hA500_0000 | (32'(tag) << 8) | 32'(b);
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (inst_rd_rdy && data_rd_rdy)
                check("single_rdy", 1, 0);
            if (inst_rd_rdy || data_rd_rdy) begin
                check("grant_expected", gnt_q.size() != 0, 1);
                if (gnt_q.size() != 0)
                    check("grant_side", data_rd_rdy ? 1 : 0, gnt_q.pop_front());
            end
            if (arvalid && arready) begin
                check("ar_expected", ar_q.size() != 0, 1);
                if (ar_q.size() != 0)
                    check("ar_fields", {arid, araddr, arlen}, ar_q.pop_front());
            end
            if (inst_ret_valid || data_ret_valid) begin
                check("ret_expected", ret_q.size() != 0, 1);
                if (ret_q.size() != 0)
                    check("ret_beat", {inst_ret_valid, inst_ret_last, data_ret_valid,
                                       data_ret_last, ret_data}, ret_q.pop_front());
            end
            if (rvalid)
                check("rready_on_beat", rready, 1);
        end
    end

    // Waits for a grant; returns one cycle after the granting edge.
    task automatic wait_grant(output int side);
        int t;
        t = 0;
        side = -1;
        while (t < 50) begin
            #1;
            if (inst_rd_rdy || data_rd_rdy) begin
                side = data_rd_rdy ? 1 : 0;
                break;
            end
            @(posedge clk); #1;
            t++;
        end
        check("grant_seen", side >= 0, 1);
        @(posedge clk); #1;
    endtask

    // AXI slave: AR handshake after ar_delay cycles, then nbeats beats,
    // with an optional foreign-ID beat inserted before beat stray_at.
    task automatic serve(input int side, input int nbeats, input int ar_delay,
                         input int stray_at, input int tag);
        int t;
        t = 0;
        while (!arvalid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("arvalid_seen", arvalid, 1);
        repeat (ar_delay) begin
            @(posedge clk); #1;
            check("arvalid_held", arvalid, 1);
        end
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            if (b == stray_at) begin
                rvalid = 1'b1; rid = 4'd2; rdata = 32'hDEAD_BEEF; rlast = 1'b1;
                @(posedge clk); #1;
            end
            rvalid = 1'b1;
            rid    = 4'(side);
            rdata  = beat_data(tag, b);
            rlast  = (b == nbeats - 1);
            ret_q.push_back(mk_ret(side, rlast, rdata));
            #1;
            check("no_rdy_in_r", {inst_rd_rdy, data_rd_rdy}, 0);
            @(posedge clk); #1;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    function automatic logic [31:0] daddr(input int k);
        return 32'h2000_0001 + 32'(k) * 32'd8;
    endfunction

    initial begin
        int s;
        int dk;
        int exp_side[5];
        exp_side = '{1, 1, 1, 0, 1};

        reset = 1'b1;
        inst_rd_req = 1'b1; inst_rd_uncached = 1'b0; inst_rd_addr = 32'h0;
        data_rd_req = 1'b1; data_rd_uncached = 1'b0; data_rd_addr = 32'h0;
        arready = 1'b0; rid = 4'd0; rdata = 32'h0; rlast = 1'b0; rvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {inst_rd_rdy, data_rd_rdy, arvalid, rready, inst_ret_valid,
                             inst_ret_last, data_ret_valid, data_ret_last}, 0);
        check("reset_ar", {arid, araddr, arlen}, 0);
        check("arsize", arsize, 3'b010);
        inst_rd_req = 1'b0;
        data_rd_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Inst-only cached line read
        gnt_q.push_back(0);
        ar_q.push_back({4'd0, 32'h1C00_0010, 8'd3});
        inst_rd_req = 1'b1; inst_rd_uncached = 1'b0; inst_rd_addr = 32'h1C00_0014;
        wait_grant(s);
        inst_rd_req = 1'b0;
        serve(0, 4, 2, -1, 1);
        check("idle_after_inst", {arvalid, rready}, 0);

        // Simultaneous: data uncached wins, inst follows after the bubble
        gnt_q.push_back(1);
        ar_q.push_back({4'd1, 32'h8000_0003, 8'd0});
        gnt_q.push_back(0);
        ar_q.push_back({4'd0, 32'h0000_1200, 8'd3});
        inst_rd_req = 1'b1; inst_rd_uncached = 1'b0; inst_rd_addr = 32'h0000_1204;
        data_rd_req = 1'b1; data_rd_uncached = 1'b1; data_rd_addr = 32'h8000_0003;
        wait_grant(s);
        data_rd_req = 1'b0;
        check("first_winner", s, 1);
        serve(1, 1, 0, -1, 2);
        check("inst_grant_after_bubble", inst_rd_rdy, 1);
        wait_grant(s);
        inst_rd_req = 1'b0;
        serve(0, 4, 0, -1, 3);

        // Starvation: inst held high against back-to-back data
        dk = 0;
        for (int i = 0; i < 5; i++) begin
            gnt_q.push_back(exp_side[i]);
            if (exp_side[i] == 1) begin
                ar_q.push_back({4'd1, daddr(dk), 8'd0});
                dk++;
            end else begin
                ar_q.push_back({4'd0, 32'h3000_0040, 8'd3});
            end
        end
        dk = 0;
        inst_rd_req = 1'b1; inst_rd_uncached = 1'b0; inst_rd_addr = 32'h3000_004C;
        data_rd_req = 1'b1; data_rd_uncached = 1'b1; data_rd_addr = daddr(0);
        for (int i = 0; i < 5; i++) begin
            wait_grant(s);
            if (exp_side[i] == 1) begin
                dk++;
                data_rd_addr = daddr(dk);
                if (dk == 4) data_rd_req = 1'b0;
                serve(1, 1, 0, -1, 10 + i);
            end else begin
                inst_rd_req = 1'b0;
                serve(0, 4, 0, -1, 10 + i);
            end
        end

        // Stray rid=2 beat (with rlast) in the middle of an inst burst
        gnt_q.push_back(0);
        ar_q.push_back({4'd0, 32'h4000_0100, 8'd3});
        inst_rd_req = 1'b1; inst_rd_uncached = 1'b0; inst_rd_addr = 32'h4000_0104;
        wait_grant(s);
        inst_rd_req = 1'b0;
        serve(0, 4, 1, 1, 20);
        check("idle_after_stray", {arvalid, rready}, 0);

        // Reset on beat 2 of a data burst
        gnt_q.push_back(1);
        ar_q.push_back({4'd1, 32'h5000_0020, 8'd3});
        data_rd_req = 1'b1; data_rd_uncached = 1'b0; data_rd_addr = 32'h5000_0024;
        wait_grant(s);
        data_rd_req = 1'b0;
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        rvalid = 1'b1; rid = 4'd1; rdata = beat_data(30, 0); rlast = 1'b0;
        ret_q.push_back(mk_ret(1, 1'b0, rdata));
        @(posedge clk); #1;
        rdata = beat_data(30, 1);
        reset = 1'b1;
        inst_rd_req = 1'b1; inst_rd_uncached = 1'b1; inst_rd_addr = 32'h6000_0008;
        #1;
        check("rst_mid_ctrl", {arvalid, rready, inst_ret_valid, data_ret_valid,
                               inst_rd_rdy, data_rd_rdy}, 0);
        check("rst_mid_ar", {arid, araddr, arlen}, 0);
        rvalid = 1'b0;
        @(posedge clk); #1;
        gnt_q.push_back(0);
        ar_q.push_back({4'd0, 32'h6000_0008, 8'd0});
        reset = 1'b0;
        @(posedge clk); #1;
        check("first_edge_grant", {arvalid, arid}, {1'b1, 4'd0});
        inst_rd_req = 1'b0;
        serve(0, 1, 0, -1, 31);

        repeat (2) @(posedge clk);
        check("queues_drained", gnt_q.size() + ar_q.size() + ret_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
